// File: rtl/reduce_gate_sweeper_if.sv
// Handshake bundle for reduce_gate_sweeper: gate select, single-shot request,
// sweep control and the registered result/status outputs.
interface reduce_gate_sweeper_if #(
  parameter int N = 3
);
  logic [2:0]   mode;
  logic [N-1:0] ext_in;
  logic         ext_valid;
  logic         start;
  logic [N-1:0] vec_out;
  logic         y;
  logic         y_valid;
  logic         busy;
  logic         done;
  logic [N:0]   ones_cnt;

  modport master (
    output mode, ext_in, ext_valid, start,
    input  vec_out, y, y_valid, busy, done, ones_cnt
  );

  modport slave (
    input  mode, ext_in, ext_valid, start,
    output vec_out, y, y_valid, busy, done, ones_cnt
  );
endinterface

// File: rtl/reduce_gate_sweeper.sv
// Registered N-input reduction gate with runtime gate select: evaluates an external
// vector on request, or sweeps all 2^N vectors and counts the TRUE results.
module reduce_gate_sweeper #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reduce_gate_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [N:0] LAST_IDX = {1'b0, {N{1'b1}}};

  state_t       state_r;
  logic [2:0]   mode_r;
  logic [N:0]   idx_r;
  logic [N-1:0] vec_r;
  logic         y_r;
  logic         y_valid_r;
  logic         busy_r;
  logic         done_r;
  logic [N:0]   ones_r;
  logic         sweep_y_s;

  // Reserved selects (6, 7) deliberately evaluate to 0.
  function automatic logic gate_eval(input logic [2:0] m, input logic [N-1:0] v);
    logic r;
    case (m)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ^v;
      3'd3:    r = ~&v;
      3'd4:    r = ~|v;
      3'd5:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign sweep_y_s = gate_eval(mode_r, idx_r[N-1:0]);

  // Control FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mode_r    <= 3'd0;
      idx_r     <= '0;
      vec_r     <= '0;
      y_r       <= 1'b0;
      y_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ones_r    <= '0;
    end else begin
      y_valid_r <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mode_r  <= bus.mode;
            ones_r  <= '0;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= SWEEP;
          end else if (bus.ext_valid) begin
            vec_r     <= bus.ext_in;
            y_r       <= gate_eval(bus.mode, bus.ext_in);
            y_valid_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SWEEP: begin
          vec_r     <= idx_r[N-1:0];
          y_r       <= sweep_y_s;
          y_valid_r <= 1'b1;
          ones_r    <= ones_r + (N+1)'(sweep_y_s);
          idx_r     <= idx_r + (N+1)'(1);
          if (idx_r == LAST_IDX) begin
            state_r <= FIN;
          end else begin
            state_r <= SWEEP;
          end
        end
        FIN: begin
          // Requests seen here are dropped; the sweep ends with a single done pulse.
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out  = vec_r;
  assign bus.y        = y_r;
  assign bus.y_valid  = y_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ones_cnt = ones_r;

endmodule

// File: tb/tb_reduce_gate_sweeper.sv
// Randomized self-checking bench for reduce_gate_sweeper (N=3 and N=8 instances)
// against a popcount-based reference of the gate truth tables.
module tb_reduce_gate_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reduce_gate_sweeper_if #(.N(3)) if3 ();
  reduce_gate_sweeper_if #(.N(8)) if8 ();

  reduce_gate_sweeper #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  reduce_gate_sweeper #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  int vec_cnt = 0;
  int err_cnt = 0;
  int held3   = 0;
  int last_y3 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: gate truth from the count of ones in the vector.
  function automatic int ref_gate(input int m, input int v, input int n);
    int p;
    p = 0;
    for (int i = 0; i < n; i++) p += (v >> i) & 1;
    case (m)
      0:       return (p == n) ? 1 : 0;
      1:       return (p > 0) ? 1 : 0;
      2:       return p % 2;
      3:       return (p == n) ? 0 : 1;
      4:       return (p == 0) ? 1 : 0;
      5:       return (p % 2 == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic sweep3(input int m, input bit disturb, input bit abort);
    int ones;
    int e;
    ones = 0;
    if3.mode  = 3'(m);
    if3.start = 1'b1;
    @(posedge clk); #1;
    if3.start = 1'b0;
    check_eq("s3_busy_at_start", 32'(if3.busy), 32'd1);
    check_eq("s3_cnt_cleared", 32'(if3.ones_cnt), 32'd0);
    check_eq("s3_no_valid_at_start", 32'(if3.y_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 3) begin
        if3.start     = 1'b0;
        if3.ext_valid = 1'b0;
      end
      e = ref_gate(m, k, 3);
      ones += e;
      check_eq("s3_y_valid", 32'(if3.y_valid), 32'd1);
      check_eq("s3_vec_out", 32'(if3.vec_out), 32'(k));
      check_eq("s3_y", 32'(if3.y), 32'(e));
      check_eq("s3_busy", 32'(if3.busy), 32'd1);
      check_eq("s3_no_done", 32'(if3.done), 32'd0);
      last_y3 = e;
      if (disturb && k == 2) begin
        if3.start     = 1'b1;
        if3.ext_valid = 1'b1;
        if3.ext_in    = 3'($urandom);
        if3.mode      = 3'd1;
      end
      if (abort && k == 4) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_vec_out", 32'(if3.vec_out), 32'd0);
        check_eq("rst_y", 32'(if3.y), 32'd0);
        check_eq("rst_y_valid", 32'(if3.y_valid), 32'd0);
        check_eq("rst_busy", 32'(if3.busy), 32'd0);
        check_eq("rst_done", 32'(if3.done), 32'd0);
        check_eq("rst_ones_cnt", 32'(if3.ones_cnt), 32'd0);
        @(posedge clk); #1;
        check_eq("rst_no_done_pulse", 32'(if3.done), 32'd0);
        check_eq("rst_still_idle", 32'(if3.busy), 32'd0);
        rst_n   = 1'b1;
        held3   = 0;
        last_y3 = 0;
        return;
      end
    end
    @(posedge clk); #1;
    check_eq("s3_done", 32'(if3.done), 32'd1);
    check_eq("s3_busy_end", 32'(if3.busy), 32'd0);
    check_eq("s3_valid_end", 32'(if3.y_valid), 32'd0);
    check_eq("s3_ones_cnt", 32'(if3.ones_cnt), 32'(ones));
    held3 = ones;
    @(posedge clk); #1;
    check_eq("s3_done_single", 32'(if3.done), 32'd0);
    check_eq("s3_no_restart", 32'(if3.busy), 32'd0);
    check_eq("s3_no_extra_valid", 32'(if3.y_valid), 32'd0);
    check_eq("s3_cnt_held", 32'(if3.ones_cnt), 32'(ones));
  endtask

  task automatic ext_one(input int m, input int v);
    int e;
    if3.mode      = 3'(m);
    if3.ext_in    = 3'(v);
    if3.ext_valid = 1'b1;
    @(posedge clk); #1;
    e = ref_gate(m, v, 3);
    check_eq("ext_y_valid", 32'(if3.y_valid), 32'd1);
    check_eq("ext_vec_out", 32'(if3.vec_out), 32'(v));
    check_eq("ext_y", 32'(if3.y), 32'(e));
    check_eq("ext_cnt_untouched", 32'(if3.ones_cnt), 32'(held3));
    last_y3 = e;
  endtask

  task automatic ext_idle();
    if3.ext_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_no_valid", 32'(if3.y_valid), 32'd0);
    check_eq("idle_y_holds", 32'(if3.y), 32'(last_y3));
  endtask

  task automatic sweep8(input int m);
    int ones;
    ones = 0;
    if8.mode  = 3'(m);
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      ones += ref_gate(m, k, 8);
      check_eq("s8_vec_out", 32'(if8.vec_out), 32'(k));
      check_eq("s8_y", 32'(if8.y), 32'(ref_gate(m, k, 8)));
      if (k == 255) check_eq("s8_last_valid", 32'(if8.y_valid), 32'd1);
    end
    @(posedge clk); #1;
    check_eq("s8_done", 32'(if8.done), 32'd1);
    check_eq("s8_busy_end", 32'(if8.busy), 32'd0);
    check_eq("s8_ones_cnt", 32'(if8.ones_cnt), 32'(ones));
  endtask

  initial begin
    if3.mode = 3'd0; if3.ext_in = 3'd0; if3.ext_valid = 1'b0; if3.start = 1'b0;
    if8.mode = 3'd0; if8.ext_in = 8'd0; if8.ext_valid = 1'b0; if8.start = 1'b0;
    #12;
    check_eq("reset_vec_out", 32'(if3.vec_out), 32'd0);
    check_eq("reset_y", 32'(if3.y), 32'd0);
    check_eq("reset_y_valid", 32'(if3.y_valid), 32'd0);
    check_eq("reset_busy", 32'(if3.busy), 32'd0);
    check_eq("reset_done", 32'(if3.done), 32'd0);
    check_eq("reset_ones_cnt", 32'(if3.ones_cnt), 32'd0);
    check_eq("reset_ones_cnt8", 32'(if8.ones_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sweep3(0, 1'b0, 1'b0);
    sweep3(2, 1'b0, 1'b0);
    sweep3(4, 1'b0, 1'b0);
    ext_one(1, 0);
    ext_one(1, 5);
    ext_idle();
    sweep3(0, 1'b1, 1'b0);
    ext_idle();
    sweep3(int'($urandom_range(0, 5)), 1'b0, 1'b1);
    sweep3(0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        sweep3(int'($urandom_range(0, 7)), 1'b0, 1'b0);
      end else begin
        for (int j = 0; j < 4; j++) ext_one(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        ext_idle();
      end
    end

    sweep8(3);
    if8.mode      = 3'd6;
    if8.ext_in    = 8'($urandom_range(1, 255));
    if8.ext_valid = 1'b1;
    @(posedge clk); #1;
    if8.ext_valid = 1'b0;
    check_eq("ext8_reserved_valid", 32'(if8.y_valid), 32'd1);
    check_eq("ext8_reserved_y", 32'(if8.y), 32'd0);
    check_eq("ext8_cnt_untouched", 32'(if8.ones_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
